base_tagpool: RTL and testbench
===============================

# base_tagpool

Free-tag pool for the base library. It sits directly downstream of the init sequencer and consumes its after-reset countdown stream of COUNT indices, loading each one into an internal free list. Once loaded, it hands out tags on an allocate stream and takes them back on a free stream. Every tag is tracked with an in-use bit, so a free of a tag that is not outstanding is flagged and dropped.

## Interface
- LOG_COUNT, 1, tag width in bits.
- COUNT, 2**LOG_COUNT, number of tags; pool depth.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; returns the block to the INIT state.
- init_v  in  1  init stream valid (from the init sequencer's dout_v).
- init_d  in  LOG_COUNT  init tag value, [0:LOG_COUNT-1].
- init_r  out  1  init stream ready.
- alloc_v  out  1  a free tag is offered.
- alloc_d  out  LOG_COUNT  offered tag, [0:LOG_COUNT-1].
- alloc_r  in  1  consumer accepts the offered tag.
- free_v  in  1  tag return valid.
- free_d  in  LOG_COUNT  returned tag.
- free_r  out  1  tag return ready.
- init_done  out  1  pool is loaded and serving requests.
- free_cnt  out  LOG_COUNT+1  number of tags currently held in the pool, [0:LOG_COUNT].
- err  out  1  sticky flag: a free was received for a tag that was not allocated.

## Operation
- Storage: COUNT-entry register array used as a circular FIFO.
  - rd_ptr and wr_ptr are LOG_COUNT bits each and wrap modulo COUNT.
  - Occupancy is a separate (LOG_COUNT+1)-bit counter, range 0..COUNT, driven directly onto free_cnt.
- in_use: COUNT-bit vector indexed by tag value.
- State machine, two states: INIT and RUN.
- INIT:
  - init_r=1, alloc_v=0, free_r=0, init_done=0.
  - Each cycle with init_v&init_r writes init_d to mem[wr_ptr], then increments wr_ptr and occupancy.
  - Values are not checked and in_use is not modified.
  - When the COUNT-th word is accepted, the next state is RUN.
- RUN:
  - init_r=0, init_done=1, free_r=1.
  - alloc_v = (occupancy!=0); alloc_d = mem[rd_ptr], read combinationally from registers.
  - Any init_v in RUN is ignored.
- Alloc (alloc_v&alloc_r): increment rd_ptr, decrement occupancy, set in_use[alloc_d].
- Free (free_v&free_r):
  - If in_use[free_d]=1: write free_d to mem[wr_ptr], increment wr_ptr and occupancy, clear in_use[free_d].
  - If in_use[free_d]=0: discard the tag, set err. Pointers, occupancy and in_use are unchanged.
  - Because invalid frees are discarded, occupancy can never exceed COUNT, so free_r needs no full check.
- Simultaneous alloc and valid free in one cycle: both take effect and occupancy is unchanged.
- Allocating tag X while freeing X in the same cycle is an invalid free (in_use[X] is still 0). Outcome: err set, the alloc proceeds, X is not pushed.
- No bypass: a tag freed while the pool is empty is not offered in the same cycle.
- Allocation order equals init order for the first COUNT allocations. After that, order follows the sequence of frees.

## Timing
- Reset values, applied asynchronously:
  - state=INIT; rd_ptr=wr_ptr=0; occupancy=0; in_use=0; err=0.
  - Resulting outputs: init_r=1, alloc_v=0, free_r=0, init_done=0, free_cnt=0, err=0.
  - mem is not reset.
- Reset mid-operation (either state) discards all contents and restarts INIT; err is cleared.
- init_r, alloc_v, alloc_d, free_r and init_done are decoded from registered state only. They have no combinational path from any input.
- Load latency: with init_v held high, COUNT accepts take COUNT cycles. init_done and alloc_v rise in the cycle after the last accept.
- Free-to-alloc latency: a valid freed tag is visible on alloc_d, with alloc_v=1, from the next cycle when the pool was empty.
- free_cnt and err update in the cycle after the triggering handshake.
- Sustained throughput: one alloc and one free per cycle.

## Test plan
- Load and drain (LOG_COUNT=2):
  - Stimulus: feed init 3,2,1,0 with init_v held high; then hold alloc_r=1.
  - Required: init_done=1 in cycle 5, free_cnt=4; alloc_d=3,2,1,0 on consecutive cycles; then alloc_v=0, free_cnt=0.
- Empty pool and free latency:
  - Stimulus: drain all tags, free tag 2.
  - Required: alloc_v=0 in the free cycle; next cycle alloc_v=1, alloc_d=2, free_cnt=1.
- Simultaneous alloc and free:
  - Stimulus: pool holds {1,0}, tag 3 outstanding; alloc tag 1 and free tag 3 in the same cycle.
  - Required: free_cnt stays 2; next offers are 0, then 3.
- Invalid frees:
  - Stimulus: free tag 0 while it is still in the pool.
  - Required: err=1 next cycle and stays 1; free_cnt unchanged; tag 0 is offered exactly once.
  - Stimulus: in the same cycle, alloc tag X and free tag X.
  - Required: err=1; X is not re-queued.
- Backpressure during load:
  - Stimulus: toggle init_v 1,0,1,0.
  - Required: only handshaked words are stored; alloc_v stays 0 until the 4th accept; free_v asserted during INIT is not accepted.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously while tags are outstanding and err=1.
  - Required: outputs take their reset values immediately; the reload proceeds as in the load-and-drain scenario.

Source files
------------

// File: rtl/base_tagpool.sv
// base_tagpool: free-tag pool loaded from the init stream, serving alloc/free handshakes
module base_tagpool #(
  parameter int LOG_COUNT = 1,
  parameter int COUNT = 2**LOG_COUNT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init_v,
  input  logic [LOG_COUNT-1:0] init_d,
  output logic                 init_r,
  output logic                 alloc_v,
  output logic [LOG_COUNT-1:0] alloc_d,
  input  logic                 alloc_r,
  input  logic                 free_v,
  input  logic [LOG_COUNT-1:0] free_d,
  output logic                 free_r,
  output logic                 init_done,
  output logic [LOG_COUNT:0]   free_cnt,
  output logic                 err
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nx;
  logic [LOG_COUNT-1:0] mem [COUNT];
  logic [LOG_COUNT-1:0] rd_ptr, wr_ptr, push_d;
  logic [LOG_COUNT:0]   occ;
  logic [COUNT-1:0]     in_use;
  logic init_fire, alloc_fire, free_fire, free_ok, push;
  always_comb begin
    init_r    = state == INIT;
    init_done = state == RUN;
    free_r    = state == RUN;
    alloc_v   = state == RUN && occ != '0;
    alloc_d   = mem[rd_ptr];
    free_cnt  = occ;
  end
  always_comb begin
    init_fire  = init_v & init_r;
    alloc_fire = alloc_v & alloc_r;
    free_fire  = free_v & free_r;
    free_ok    = free_fire & in_use[free_d];
    push       = init_fire | free_ok;
    push_d     = state == INIT ? init_d : free_d;
  end
  always_comb
    state_nx = (state == INIT && init_fire && occ == (LOG_COUNT+1)'(COUNT-1)) ? RUN : state;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= INIT;
    else state <= state_nx;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      in_use <= '0;
      err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (alloc_fire) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + (LOG_COUNT+1)'(push) - (LOG_COUNT+1)'(alloc_fire);
      if (alloc_fire) in_use[alloc_d] <= 1'b1;
      if (free_ok) in_use[free_d] <= 1'b0;
      if (free_fire && !in_use[free_d]) err <= 1'b1;
    end
  // storage is deliberately unreset; occupancy gates every read
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_d;
endmodule

// File: tb/tb_base_tagpool.sv
// tb_base_tagpool: scoreboard bench for base_tagpool with LOG_COUNT=2
module tb_base_tagpool;
  localparam int L = 2, N = 4;
  logic clk = 0, reset = 1, init_v = 0, alloc_r = 0, free_v = 0;
  logic [L-1:0] init_d = '0, free_d = '0;
  logic init_r, alloc_v, free_r, init_done, err;
  logic [L-1:0] alloc_d;
  logic [L:0] free_cnt;
  int total = 0, bad = 0;
  int q[$];
  bit run = 0, m_err = 0;
  bit [N-1:0] m_use = '0;
  always #5 clk = ~clk;
  base_tagpool #(.LOG_COUNT(L)) dut (
    .clk(clk), .reset(reset), .init_v(init_v), .init_d(init_d), .init_r(init_r),
    .alloc_v(alloc_v), .alloc_d(alloc_d), .alloc_r(alloc_r), .free_v(free_v),
    .free_d(free_d), .free_r(free_r), .init_done(init_done), .free_cnt(free_cnt), .err(err)
  );
  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task outs();
    chk("init_r", 32'(init_r), 32'(!run));
    chk("free_r", 32'(free_r), 32'(run));
    chk("init_done", 32'(init_done), 32'(run));
    chk("alloc_v", 32'(alloc_v), 32'(run && q.size() != 0));
    chk("free_cnt", 32'(free_cnt), 32'(q.size()));
    chk("err", 32'(err), 32'(m_err));
    if (run && q.size() != 0) chk("alloc_d", 32'(alloc_d), 32'(q[0]));
  endtask
  task model_reset();
    q.delete();
    run = 0;
    m_err = 0;
    m_use = '0;
  endtask
  task cyc(input bit iv, input int id, input bit ar, input bit fv, input int fd);
    bit ok;
    init_v = iv; init_d = id[L-1:0]; alloc_r = ar; free_v = fv; free_d = fd[L-1:0];
    @(negedge clk);
    outs();
    if (!run) begin
      if (iv) begin
        q.push_back(id);
        if (q.size() == N) run = 1;
      end
    end else begin
      ok = m_use[fd];
      if (ar && q.size() != 0) begin
        m_use[q[0]] = 1;
        void'(q.pop_front());
      end
      if (fv) begin
        if (ok) begin
          q.push_back(fd);
          m_use[fd] = 0;
        end else m_err = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task drain();
    while (q.size() != 0) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
  endtask
  task async_reset();
    #2 reset = 1;
    #1 model_reset();
    outs();
    @(posedge clk);
    #1 reset = 0;
  endtask
  initial begin
    #1 outs();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    for (int i = 3; i >= 0; i--) cyc(1, i, 0, 0, 0);
    drain();
    cyc(0, 0, 0, 1, 2);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 3);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    drain();
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 0);
    async_reset();
    cyc(1, 0, 0, 1, 0);
    cyc(0, 3, 0, 1, 1);
    cyc(1, 1, 0, 1, 2);
    cyc(0, 3, 0, 0, 0);
    cyc(1, 2, 0, 1, 3);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 3, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    drain();
    cyc(0, 0, 0, 1, 3);
    async_reset();
    for (int i = 3; i >= 0; i--) cyc(1, i, 0, 0, 0);
    drain();
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
